// File: rtl/input_feed_pkg.sv
// Shared types, constants and helpers for the input feed scheduler.
package input_feed_pkg;

    localparam int INPUT_WIDTH    = 32;
    localparam int OUTPUT_WIDTH   = 8;
    localparam int BYTES_PER_WORD = INPUT_WIDTH / OUTPUT_WIDTH;
    localparam int CNT_WIDTH      = 16;
    // Wide enough for CNT_WIDTH words times BYTES_PER_WORD without overflow.
    localparam int BYTE_CNT_WIDTH = CNT_WIDTH + $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        FILL     = 3'd2,
        FEED     = 3'd3,
        PASS_END = 3'd4,
        DONE     = 3'd5
    } feed_state_t;

    // Number of activation bytes delivered by one pass of num_words FIFO words.
    function automatic logic [BYTE_CNT_WIDTH-1:0] expected_bytes(input logic [CNT_WIDTH-1:0] num_words);
        logic [BYTE_CNT_WIDTH-1:0] words_ext;
        words_ext = {{(BYTE_CNT_WIDTH-CNT_WIDTH){1'b0}}, num_words};
        return words_ext * BYTE_CNT_WIDTH'(BYTES_PER_WORD);
    endfunction

endpackage

// File: rtl/feed_stall_watchdog.sv
// Counts consecutive no-data cycles while enabled and pulses STALL when the
// run reaches STALL_LIMIT. The run restarts whenever ENABLE drops.
module feed_stall_watchdog #(
    parameter int STALL_LIMIT = 16
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ENABLE,
    input  logic DATA_VALID,
    output logic STALL
);

    localparam int SW = $clog2(STALL_LIMIT + 1);

    logic [SW-1:0] stall_cnt;

    // The cycle that would make the run STALL_LIMIT long raises the pulse.
    assign STALL = ENABLE & ~DATA_VALID & (stall_cnt == SW'(STALL_LIMIT - 1));

    // Run-length counter of idle cycles; cleared by data, disable or a pulse.
    always_ff @(posedge CLK) begin
        if (RESET || !ENABLE || DATA_VALID || STALL) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + SW'(1);
        end
    end

endmodule

// File: rtl/input_feed_scheduler.sv
// Sequences clear / fill / feed for every pass of one activation job and
// reports pass and job completion plus a sticky overfill/underrun error.
//
// Command handshake: a command is taken on a rising CLK edge where both
// CMD_VALID and CMD_READY are high; CMD_READY is high only in IDLE, and
// CMD_VALID in any other state is ignored.
module input_feed_scheduler
    import input_feed_pkg::*;
#(
    parameter int FIFO_DEPTH  = 64,
    parameter int STALL_LIMIT = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 CMD_VALID,
    output logic                 CMD_READY,
    input  logic [CNT_WIDTH-1:0] CMD_NUM_WORDS,
    input  logic [CNT_WIDTH-1:0] CMD_NUM_PASSES,
    input  logic                 FIFO_WR_CMD,
    input  logic                 FIFO_FULL,
    input  logic                 FIFO_EMPTY,
    input  logic                 DATA_VALID,
    input  logic                 CONSUMER_READY,
    output logic                 CLEAR_FIFO,
    output logic                 START_FEED,
    output logic                 REFILL_REQ,
    output logic                 PASS_DONE,
    output logic                 JOB_DONE,
    output logic [CNT_WIDTH-1:0] PASS_IDX,
    output logic                 BUSY,
    output logic                 ERROR,
    output logic [2:0]           DBG_STATE
);

    feed_state_t               state, state_next;
    logic [CNT_WIDTH-1:0]      num_words, num_passes, wr_cnt, pass_idx;
    logic [BYTE_CNT_WIDTH-1:0] byte_cnt, byte_target;
    logic                      error_q, wr_accept, wr_done, stall;
    logic                      set_error, clr_error, latch_cmd;
    logic                      unused_inputs;

    // Fill level is tracked by counting accepted writes, so FIFO_EMPTY is not needed.
    assign unused_inputs = FIFO_EMPTY;

    assign wr_accept   = FIFO_WR_CMD & ~FIFO_FULL;
    assign wr_done     = (wr_cnt == num_words);
    assign byte_target = expected_bytes(num_words);

    feed_stall_watchdog #(
        .STALL_LIMIT (STALL_LIMIT)
    ) u_watchdog (
        .CLK        (CLK),
        .RESET      (RESET),
        .ENABLE     (state == FEED),
        .DATA_VALID (DATA_VALID),
        .STALL      (stall)
    );

    // Next-state logic plus the single-cycle strobes that steer the datapath.
    always_comb begin
        state_next = state;
        set_error  = 1'b0;
        clr_error  = 1'b0;
        latch_cmd  = 1'b0;
        START_FEED = 1'b0;
        case (state)
            IDLE: begin
                if (CMD_VALID) begin
                    latch_cmd = 1'b1;
                    clr_error = 1'b1;
                    if (CMD_NUM_WORDS == '0 || CMD_NUM_PASSES == '0) begin
                        state_next = DONE;
                    end else if (CMD_NUM_WORDS > CNT_WIDTH'(FIFO_DEPTH)) begin
                        set_error = 1'b1;
                    end else begin
                        state_next = CLEAR;
                    end
                end
            end
            CLEAR: state_next = FILL;
            FILL: begin
                // A write beyond the pass size is an overfill and is dropped.
                if (wr_accept && wr_done) set_error = 1'b1;
                // Uses the registered count, so the last write and the start never coincide.
                if (wr_done && CONSUMER_READY) begin
                    START_FEED = 1'b1;
                    state_next = FEED;
                end
            end
            FEED: begin
                if (wr_accept) set_error = 1'b1;
                if (DATA_VALID && (byte_cnt + BYTE_CNT_WIDTH'(1) == byte_target)) begin
                    state_next = PASS_END;
                end else if (stall) begin
                    set_error  = 1'b1;
                    state_next = PASS_END;
                end
            end
            PASS_END: state_next = (pass_idx == num_passes - CNT_WIDTH'(1)) ? DONE : CLEAR;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    // Command latch, counters and the sticky error flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            num_words  <= '0;
            num_passes <= '0;
            wr_cnt     <= '0;
            byte_cnt   <= '0;
            pass_idx   <= '0;
            error_q    <= 1'b0;
        end else begin
            if (latch_cmd) begin
                num_words  <= CMD_NUM_WORDS;
                num_passes <= CMD_NUM_PASSES;
            end
            if (set_error)      error_q <= 1'b1;
            else if (clr_error) error_q <= 1'b0;
            case (state)
                CLEAR: wr_cnt <= '0;
                FILL: begin
                    if (wr_accept && !wr_done) wr_cnt <= wr_cnt + CNT_WIDTH'(1);
                    if (START_FEED)            byte_cnt <= '0;
                end
                FEED:     if (DATA_VALID) byte_cnt <= byte_cnt + BYTE_CNT_WIDTH'(1);
                PASS_END: if (state_next == CLEAR) pass_idx <= pass_idx + CNT_WIDTH'(1);
                DONE:     pass_idx <= '0;
                default: ;
            endcase
        end
    end

    assign CMD_READY  = (state == IDLE);
    assign BUSY       = (state != IDLE);
    assign CLEAR_FIFO = (state == CLEAR);
    assign REFILL_REQ = (state == FILL) && (wr_cnt < num_words);
    assign PASS_DONE  = (state == PASS_END);
    assign JOB_DONE   = (state == DONE);
    assign PASS_IDX   = pass_idx;
    assign ERROR      = error_q;
    assign DBG_STATE  = state;

endmodule

// File: tb/tb_input_feed_scheduler.sv
// Directed bench for input_feed_scheduler: pulse events are checked against
// a queue of expected events filled when each command is issued.
module tb_input_feed_scheduler;
    import input_feed_pkg::*;

    localparam int EW = 20;
    localparam logic [3:0] EV_CLEAR = 4'd1;
    localparam logic [3:0] EV_START = 4'd2;
    localparam logic [3:0] EV_PASS  = 4'd3;
    localparam logic [3:0] EV_JOB   = 4'd4;

    logic                 CLK;
    logic                 RESET;
    logic                 CMD_VALID;
    logic                 CMD_READY;
    logic [CNT_WIDTH-1:0] CMD_NUM_WORDS;
    logic [CNT_WIDTH-1:0] CMD_NUM_PASSES;
    logic                 FIFO_WR_CMD;
    logic                 FIFO_FULL;
    logic                 FIFO_EMPTY;
    logic                 DATA_VALID;
    logic                 CONSUMER_READY;
    logic                 CLEAR_FIFO;
    logic                 START_FEED;
    logic                 REFILL_REQ;
    logic                 PASS_DONE;
    logic                 JOB_DONE;
    logic [CNT_WIDTH-1:0] PASS_IDX;
    logic                 BUSY;
    logic                 ERROR;
    logic [2:0]           DBG_STATE;

    int checks   = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_obs, mon_exp;
    logic          mon_hit;

    input_feed_scheduler dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .CMD_VALID      (CMD_VALID),
        .CMD_READY      (CMD_READY),
        .CMD_NUM_WORDS  (CMD_NUM_WORDS),
        .CMD_NUM_PASSES (CMD_NUM_PASSES),
        .FIFO_WR_CMD    (FIFO_WR_CMD),
        .FIFO_FULL      (FIFO_FULL),
        .FIFO_EMPTY     (FIFO_EMPTY),
        .DATA_VALID     (DATA_VALID),
        .CONSUMER_READY (CONSUMER_READY),
        .CLEAR_FIFO     (CLEAR_FIFO),
        .START_FEED     (START_FEED),
        .REFILL_REQ     (REFILL_REQ),
        .PASS_DONE      (PASS_DONE),
        .JOB_DONE       (JOB_DONE),
        .PASS_IDX       (PASS_IDX),
        .BUSY           (BUSY),
        .ERROR          (ERROR),
        .DBG_STATE      (DBG_STATE)
    );

    // Clock and run-time guard.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Expected pulse sequence of one job that runs to its normal end.
    task automatic push_job(input int words, input int passes);
        if (words == 0 || passes == 0) begin
            exp_q.push_back({EV_JOB, 16'd0});
        end else if (words <= 64) begin
            for (int p = 0; p < passes; p++) begin
                exp_q.push_back({EV_CLEAR, 16'(p)});
                exp_q.push_back({EV_START, 16'(p)});
                exp_q.push_back({EV_PASS,  16'(p)});
            end
            exp_q.push_back({EV_JOB, 16'd0});
        end
    endtask

    task automatic wait_state(input feed_state_t st, input int max_cycles, input string tag);
        for (int i = 0; i < max_cycles; i++) begin
            if (DBG_STATE == st) break;
            tick();
        end
        check(tag, 32'(DBG_STATE), 32'(st));
    endtask

    task automatic send_cmd(input int words, input int passes);
        for (int i = 0; i < 100; i++) begin
            if (CMD_READY) break;
            tick();
        end
        check("cmd_ready_wait", 32'(CMD_READY), 32'd1);
        push_job(words, passes);
        CMD_VALID      = 1'b1;
        CMD_NUM_WORDS  = 16'(words);
        CMD_NUM_PASSES = 16'(passes);
        tick();
        CMD_VALID = 1'b0;
    endtask

    task automatic write_words(input int n);
        wait_state(FILL, 50, "wait_fill");
        FIFO_WR_CMD = 1'b1;
        repeat (n) tick();
        FIFO_WR_CMD = 1'b0;
    endtask

    task automatic feed_bytes(input int n);
        wait_state(FEED, 50, "wait_feed");
        DATA_VALID = 1'b1;
        repeat (n) tick();
        DATA_VALID = 1'b0;
    endtask

    // Scoreboard: every pulse seen on the negative edge must match the queue head.
    always @(negedge CLK) begin
        if (!RESET) begin
            mon_hit = 1'b1;
            if (CLEAR_FIFO)      mon_obs = {EV_CLEAR, PASS_IDX};
            else if (START_FEED) mon_obs = {EV_START, PASS_IDX};
            else if (PASS_DONE)  mon_obs = {EV_PASS,  PASS_IDX};
            else if (JOB_DONE)   mon_obs = {EV_JOB,   16'd0};
            else                 mon_hit = 1'b0;
            if (mon_hit) begin
                check("event_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    check("event", 32'(mon_obs), 32'(mon_exp));
                end
            end
        end
    end

    initial begin
        RESET = 1'b1; CMD_VALID = 1'b0; CMD_NUM_WORDS = '0; CMD_NUM_PASSES = '0;
        FIFO_WR_CMD = 1'b0; FIFO_FULL = 1'b0; FIFO_EMPTY = 1'b0;
        DATA_VALID = 1'b0; CONSUMER_READY = 1'b0;
        repeat (3) tick();

        // Reset state.
        check("rst_cmd_ready", 32'(CMD_READY), 32'd1);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_pulses", 32'({CLEAR_FIFO, START_FEED, REFILL_REQ, PASS_DONE, JOB_DONE}), 32'd0);
        check("rst_pass_idx", 32'(PASS_IDX), 32'd0);
        check("rst_error", 32'(ERROR), 32'd0);
        RESET = 1'b0;
        tick();

        // Basic job: 4 words, 1 pass.
        CONSUMER_READY = 1'b1;
        send_cmd(4, 1);
        check("basic_clear", 32'(CLEAR_FIFO), 32'd1);
        check("basic_busy", 32'(BUSY), 32'd1);
        check("basic_cmd_ready", 32'(CMD_READY), 32'd0);
        tick();
        check("basic_clear_one_cycle", 32'(CLEAR_FIFO), 32'd0);
        check("basic_refill", 32'(REFILL_REQ), 32'd1);
        write_words(4);
        check("basic_refill_off", 32'(REFILL_REQ), 32'd0);
        check("basic_start", 32'(START_FEED), 32'd1);
        feed_bytes(16);
        check("basic_pass_done", 32'(PASS_DONE), 32'd1);
        tick();
        check("basic_job_done", 32'(JOB_DONE), 32'd1);
        check("basic_pass_done_off", 32'(PASS_DONE), 32'd0);
        tick();
        check("basic_idle", 32'(CMD_READY), 32'd1);
        check("basic_error", 32'(ERROR), 32'd0);
        check("basic_drained", 32'(exp_q.size()), 32'd0);

        // Multi-pass: 2 words, 3 passes.
        send_cmd(2, 3);
        for (int p = 0; p < 3; p++) begin
            write_words(2);
            check("multi_pass_idx_fill", 32'(PASS_IDX), 32'(p));
            feed_bytes(8);
            check("multi_pass_done", 32'(PASS_DONE), 32'd1);
            check("multi_pass_idx_end", 32'(PASS_IDX), 32'(p));
        end
        wait_state(IDLE, 20, "multi_idle");
        check("multi_drained", 32'(exp_q.size()), 32'd0);
        check("multi_pass_idx_reset", 32'(PASS_IDX), 32'd0);

        // Back-pressure: consumer not ready for 20 cycles after the fill.
        CONSUMER_READY = 1'b0;
        send_cmd(3, 1);
        write_words(3);
        for (int i = 0; i < 20; i++) begin
            check("bp_withheld", 32'({START_FEED, REFILL_REQ}), 32'd0);
            tick();
        end
        check("bp_still_fill", 32'(DBG_STATE), 32'(FILL));
        CONSUMER_READY = 1'b1;
        #1;
        check("bp_start", 32'(START_FEED), 32'd1);
        tick();
        check("bp_feed", 32'(DBG_STATE), 32'(FEED));
        feed_bytes(12);
        wait_state(IDLE, 20, "bp_idle");
        check("bp_error", 32'(ERROR), 32'd0);

        // Bad commands.
        send_cmd(65, 1);
        check("bad_too_big_error", 32'(ERROR), 32'd1);
        check("bad_too_big_busy", 32'(BUSY), 32'd0);
        tick();
        check("bad_too_big_idle", 32'(BUSY), 32'd0);
        send_cmd(0, 5);
        check("bad_zero_words_job", 32'(JOB_DONE), 32'd1);
        check("bad_zero_clears_error", 32'(ERROR), 32'd0);
        tick();
        send_cmd(4, 0);
        check("bad_zero_passes_job", 32'(JOB_DONE), 32'd1);
        tick();
        send_cmd(65, 1);
        check("bad_error_again", 32'(ERROR), 32'd1);
        send_cmd(2, 1);
        check("good_clears_error", 32'(ERROR), 32'd0);
        check("good_clear", 32'(CLEAR_FIFO), 32'd1);
        write_words(2);
        feed_bytes(8);
        wait_state(IDLE, 20, "good_idle");
        check("bad_drained", 32'(exp_q.size()), 32'd0);

        // Overfill: a fifth write for a 4-word pass.
        CONSUMER_READY = 1'b0;
        send_cmd(4, 1);
        write_words(5);
        check("ovf_error", 32'(ERROR), 32'd1);
        check("ovf_refill", 32'(REFILL_REQ), 32'd0);
        check("ovf_in_fill", 32'(DBG_STATE), 32'(FILL));
        CONSUMER_READY = 1'b1;
        feed_bytes(16);
        check("ovf_count_kept", 32'(DBG_STATE), 32'(PASS_END));
        wait_state(IDLE, 20, "ovf_idle");
        check("ovf_error_sticky", 32'(ERROR), 32'd1);

        // Underrun: DATA_VALID low for 16 cycles in FEED.
        send_cmd(4, 1);
        check("unr_error_cleared", 32'(ERROR), 32'd0);
        write_words(4);
        wait_state(FEED, 20, "unr_feed");
        repeat (15) tick();
        check("unr_still_feed", 32'(DBG_STATE), 32'(FEED));
        check("unr_no_error_yet", 32'(ERROR), 32'd0);
        tick();
        check("unr_error", 32'(ERROR), 32'd1);
        check("unr_pass_done", 32'(PASS_DONE), 32'd1);
        wait_state(IDLE, 20, "unr_idle");
        check("unr_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of FEED.
        send_cmd(4, 2);
        write_words(4);
        feed_bytes(5);
        check("rmid_in_feed", 32'(DBG_STATE), 32'(FEED));
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        exp_q.delete();
        check("rmid_busy", 32'(BUSY), 32'd0);
        check("rmid_cmd_ready", 32'(CMD_READY), 32'd1);
        check("rmid_pass_idx", 32'(PASS_IDX), 32'd0);
        check("rmid_no_pulse", 32'({PASS_DONE, JOB_DONE, CLEAR_FIFO}), 32'd0);
        repeat (3) begin
            tick();
            check("rmid_quiet", 32'({PASS_DONE, JOB_DONE, START_FEED}), 32'd0);
        end
        send_cmd(2, 1);
        write_words(2);
        feed_bytes(8);
        wait_state(IDLE, 20, "rmid_idle");
        check("rmid_error", 32'(ERROR), 32'd0);

        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
